// File: rtl/ccr_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccr_branch_unit_pkg
// Description : Shared FSM state type, branch condition codes and NZVC flag
//               bit positions for the CCR branch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ccr_branch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HAZARD = 2'd1,
        ST_EVAL   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_NEVER  = 4'd1;
    localparam logic [3:0] COND_BEQ    = 4'd2;
    localparam logic [3:0] COND_BNE    = 4'd3;
    localparam logic [3:0] COND_BMI    = 4'd4;
    localparam logic [3:0] COND_BPL    = 4'd5;
    localparam logic [3:0] COND_BVS    = 4'd6;
    localparam logic [3:0] COND_BVC    = 4'd7;
    localparam logic [3:0] COND_BCS    = 4'd8;
    localparam logic [3:0] COND_BCC    = 4'd9;
    localparam logic [3:0] COND_BHI    = 4'd10;
    localparam logic [3:0] COND_BLS    = 4'd11;
    localparam logic [3:0] COND_BGE    = 4'd12;
    localparam logic [3:0] COND_BLT    = 4'd13;
    localparam logic [3:0] COND_BGT    = 4'd14;
    localparam logic [3:0] COND_BLE    = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage
`default_nettype wire

// File: rtl/ccr_branch_unit_branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_eval
// Description : Combinational 6800-style branch condition evaluator
//               (condition code + NZVC flags -> taken).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import ccr_branch_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzvc,
    output logic       taken
);

    logic w_n, w_z, w_v, w_c;

    assign w_n = nzvc[FLAG_N];
    assign w_z = nzvc[FLAG_Z];
    assign w_v = nzvc[FLAG_V];
    assign w_c = nzvc[FLAG_C];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
            COND_BEQ:    taken = w_z;
            COND_BNE:    taken = ~w_z;
            COND_BMI:    taken = w_n;
            COND_BPL:    taken = ~w_n;
            COND_BVS:    taken = w_v;
            COND_BVC:    taken = ~w_v;
            COND_BCS:    taken = w_c;
            COND_BCC:    taken = ~w_c;
            COND_BHI:    taken = ~w_c & ~w_z;
            COND_BLS:    taken = w_c | w_z;
            COND_BGE:    taken = (w_n == w_v);
            COND_BLT:    taken = (w_n != w_v);
            COND_BGT:    taken = ~w_z & (w_n == w_v);
            COND_BLE:    taken = w_z | (w_n != w_v);
            default:     taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ccr_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ccr_branch_unit
// Description : Latches ALU result/NZVC flags and answers branch-condition
//               requests over a req/ack handshake. Optional CCR shadow
//               register (save/restore/swap) enabled by CCR_SHADOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ccr_branch_unit
    import ccr_branch_unit_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter logic [3:0] CCR_RESET  = 4'b0000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Result_In,
    input  logic [3:0]            NZVC_In,
    input  logic                  ALU_Valid,
`ifdef CCR_SHADOW_EN
    input  logic                  CCR_Save,
    input  logic                  CCR_Restore,
`endif
    input  logic                  Branch_Req,
    input  logic [3:0]            Branch_Cond,
    output logic                  Branch_Ack,
    output logic                  Branch_Taken,
    output logic                  Busy,
    output logic [3:0]            CCR,
    output logic [DATA_WIDTH-1:0] Result_Reg
);

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_ccr;
    logic [3:0]            w_ccr_next;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_taken;
    logic                  w_taken;

    // ------------------------------------------------------------------
    // Result / CCR capture; ALU writes always win over a shadow restore
    // ------------------------------------------------------------------
`ifdef CCR_SHADOW_EN
    logic [3:0] r_shadow;

    always_comb begin
        w_ccr_next = r_ccr;
        if (ALU_Valid)
            w_ccr_next = NZVC_In;
        else if (CCR_Restore)
            w_ccr_next = r_shadow;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            r_shadow <= CCR_RESET;
        else if (CCR_Save)
            r_shadow <= r_ccr;
    end
`else
    always_comb begin
        w_ccr_next = r_ccr;
        if (ALU_Valid)
            w_ccr_next = NZVC_In;
    end
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ccr    <= CCR_RESET;
            r_result <= '0;
        end else begin
            r_ccr <= w_ccr_next;
            if (ALU_Valid)
                r_result <= Result_In;
        end
    end

    // ------------------------------------------------------------------
    // Branch handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Branch_Req)
                    w_next_state = ALU_Valid ? ST_HAZARD : ST_EVAL;
            end
            ST_HAZARD: w_next_state = ST_EVAL;
            ST_EVAL:   w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    branch_cond_eval u_cond_eval (
        .cond  (Branch_Cond),
        .nzvc  (r_ccr),
        .taken (w_taken)
    );

    // Evaluated against the pre-edge CCR, so an ALU write in EVAL is not seen
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            r_taken <= 1'b0;
        else if (r_state == ST_EVAL)
            r_taken <= w_taken;
    end

    always_comb begin
        Busy         = (r_state != ST_IDLE);
        Branch_Ack   = (r_state == ST_RESP);
        Branch_Taken = (r_state == ST_RESP) & r_taken;
    end

    assign CCR        = r_ccr;
    assign Result_Reg = r_result;

endmodule
`default_nettype wire
